// File: rtl/instr_fetch_queue.sv
`default_nettype none
// instr_fetch_queue: fetch PC owner, fixed-latency imem requester and FWFT instruction queue.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched/perf_flushed/perf_stall_cycles counters.
module instr_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] c_reset_pc = RESET_PC & ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_halted;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];

  logic            w_flush;
  logic [CW-1:0]   w_occ;
  logic            w_room;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // Occupancy counts the in-flight word so a response always has a free slot.
  assign w_occ         = r_count + CW'(r_inflight);
  assign w_room        = w_occ < CW'(DEPTH);
  assign w_flush       = redirect_valid && (r_state != ST_BOOT);
  assign w_issue       = (r_state == ST_RUN) && !redirect_valid && !halt_req && w_room;
  assign w_push        = r_inflight && !w_flush;
  assign w_pop         = (r_count != '0) && instr_ready && !w_flush;
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_mem_instr[r_rd];
  assign instr_pc    = r_mem_pc[r_rd];
  assign halted      = r_halted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_BOOT;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (halt_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!halt_req) begin
            r_state <= ST_RUN;
          end else if (!r_inflight) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= c_reset_pc;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_req_pc   <= r_fetch_pc;
      end
      // A flush drops both the queue and the response arriving this cycle.
      if (w_flush) begin
        r_fetch_pc <= w_redirect_pc;
        r_count    <= '0;
        r_wr       <= '0;
        r_rd       <= '0;
      end else begin
        if (w_push) begin
          r_mem_instr[r_wr] <= imem_rdata;
          r_mem_pc[r_wr]    <= r_req_pc;
          r_wr              <= r_wr + AW'(1);
        end
        if (w_pop) r_rd <= r_rd + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_stall;
  logic [32:0] w_flushed_sum;
  logic        w_stall;

  assign w_flushed_sum = {1'b0, r_perf_flushed} + 33'(r_count) + 33'(r_inflight);
  assign w_stall       = (r_state == ST_RUN) && !redirect_valid && !halt_req && !w_room;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_flush) r_perf_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_flushed      = r_perf_flushed;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire
